// File: rtl/rom_arbiter.sv
// Two-master Wishbone B3 arbiter in front of a single boot ROM slave.
// Ownership is held for the owner's whole cycle; a watchdog returns err on a stalled strobe.
module rom_arbiter #(
  parameter int addr_width = 8,
  parameter int timeout    = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [addr_width-1:0] m0_adr_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic [31:0]           m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [addr_width-1:0] m1_adr_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic [31:0]           m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [addr_width-1:0] s_adr_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_ack_i
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [15:0] CNT_LAST = 16'(timeout - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stb_raw;
  logic        err;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) state_d = m1_cyc_i ? OWN1 : IDLE;
      OWN1: if (!m1_cyc_i) state_d = m0_cyc_i ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Last-served flag tracks the most recent entry into an OWN state.
  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == OWN0) last_d = 1'b0;
      if (state_d == OWN1) last_d = 1'b1;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    case (state_q)
      OWN0: begin
        s_adr_o = m0_adr_i;
        s_cyc_o = m0_cyc_i;
        stb_raw = m0_stb_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
      end
      OWN1: begin
        s_adr_o = m1_adr_i;
        s_cyc_o = m1_cyc_i;
        stb_raw = m1_stb_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
      end
      default: ;
    endcase
  end

  // The err cycle masks the strobe so the slave sees the request withdrawn.
  assign err      = (state_q != IDLE) && stb_raw && !s_ack_i && (cnt_q == CNT_LAST);
  assign s_stb_o  = stb_raw && !err;
  assign m0_ack_o = s_ack_i && (state_q == OWN0);
  assign m1_ack_o = s_ack_i && (state_q == OWN1);
  assign m0_err_o = err && (state_q == OWN0);
  assign m1_err_o = err && (state_q == OWN1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (state_q == IDLE || state_d != state_q || s_ack_i || !stb_raw || err)
      cnt_d = '0;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: expected grants are queued as requests are driven
// and popped when the slave acknowledges.
module tb_rom_arbiter;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [7:0]  m0_adr_i, m1_adr_i;
  logic        m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [7:0]  s_adr_o;
  logic        s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  typedef struct {
    logic       own;
    logic [7:0] adr;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  rom_arbiter #(.addr_width(8), .timeout(4)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic own, input logic [7:0] adr);
    exp_t e;
    e.own = own;
    e.adr = adr;
    sb.push_back(e);
  endtask

  // Acks the current slave request and compares it against the oldest queued grant.
  task automatic grant_check(input string tag);
    exp_t e;
    s_ack_i = 1'b1;
    #1;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_adr"},  32'(s_adr_o),  32'(e.adr));
      chk({tag, "_cyc"},  32'(s_cyc_o),  32'd1);
      chk({tag, "_ack0"}, 32'(m0_ack_o), 32'(e.own == 1'b0));
      chk({tag, "_ack1"}, 32'(m1_ack_o), 32'(e.own == 1'b1));
    end
  endtask

  initial begin
    logic [2:0] exp_cti;
    logic [7:0] nadr;
    wb_rst = 1'b1;
    m0_adr_i = '0; m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = '0; m0_bte_i = '0;
    m1_adr_i = '0; m1_cyc_i = 0; m1_stb_i = 0; m1_cti_i = '0; m1_bte_i = '0;
    s_dat_i = 32'hdeadbeef; s_ack_i = 1'b0;
    tick(); tick();

    chk("rst_cyc",  32'(s_cyc_o),  32'd0);
    chk("rst_stb",  32'(s_stb_o),  32'd0);
    chk("rst_adr",  32'(s_adr_o),  32'd0);
    chk("rst_cti",  32'(s_cti_o),  32'd0);
    chk("rst_bte",  32'(s_bte_o),  32'd0);
    chk("rst_ack0", 32'(m0_ack_o), 32'd0);
    chk("rst_ack1", 32'(m1_ack_o), 32'd0);
    chk("rst_err0", 32'(m0_err_o), 32'd0);
    chk("rst_err1", 32'(m1_err_o), 32'd0);
    chk("rst_dat0", m0_dat_o, 32'hdeadbeef);
    chk("rst_dat1", m1_dat_o, 32'hdeadbeef);
    wb_rst = 1'b0;
    tick();

    // Stray ack while idle.
    s_ack_i = 1'b1; #1;
    chk("idle_ack0", 32'(m0_ack_o), 32'd0);
    chk("idle_ack1", 32'(m1_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b0;

    // Simultaneous request after reset.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h10;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h20;
    push(1'b0, 8'h10); push(1'b1, 8'h20);
    #1;
    chk("grant_latency_cyc", 32'(s_cyc_o), 32'd0);
    tick();
    grant_check("arb_m0");
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    grant_check("arb_m1");
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    chk("arb_idle_cyc", 32'(s_cyc_o), 32'd0);

    // m1 burst, m0 waiting throughout.
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'h40; m1_cti_i = 3'b010;
    push(1'b1, 8'h40);
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h50;
    for (int i = 0; i < 4; i++) begin
      exp_cti = (i == 3) ? 3'b111 : 3'b010;
      m1_adr_i = 8'h40 + 8'(i);
      m1_cti_i = exp_cti;
      if (i > 0) push(1'b1, m1_adr_i);
      grant_check($sformatf("burst%0d", i));
      chk($sformatf("burst%0d_cti", i), 32'(s_cti_o), 32'(exp_cti));
      tick();
    end
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_cti_i = '0;
    push(1'b0, 8'h50);
    tick();
    grant_check("after_burst");
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // Watchdog with timeout=4 and a silent slave.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'h70;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("wd%0d_err0", i), 32'(m0_err_o), 32'(i == 4));
      chk($sformatf("wd%0d_stb", i),  32'(s_stb_o),  32'(i != 4));
      chk($sformatf("wd%0d_err1", i), 32'(m1_err_o), 32'd0);
      chk($sformatf("wd%0d_cyc", i),  32'(s_cyc_o),  32'd1);
      tick();
    end
    chk("wd_after_err0", 32'(m0_err_o), 32'd0);
    chk("wd_after_stb",  32'(s_stb_o),  32'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // Reset in the middle of an m1 burst.
    s_dat_i = 32'h12345678;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 8'ha0; m1_cti_i = 3'b010;
    push(1'b1, 8'ha0);
    tick();
    grant_check("rst_beat1");
    tick();
    m1_adr_i = 8'ha1; wb_rst = 1'b1;
    tick();
    chk("mid_rst_cyc",  32'(s_cyc_o),  32'd0);
    chk("mid_rst_stb",  32'(s_stb_o),  32'd0);
    chk("mid_rst_adr",  32'(s_adr_o),  32'd0);
    chk("mid_rst_cti",  32'(s_cti_o),  32'd0);
    chk("mid_rst_ack0", 32'(m0_ack_o), 32'd0);
    chk("mid_rst_ack1", 32'(m1_ack_o), 32'd0);
    chk("mid_rst_err1", 32'(m1_err_o), 32'd0);
    chk("mid_rst_dat1", m1_dat_o, 32'h12345678);
    wb_rst = 1'b0; s_ack_i = 1'b0;
    m1_adr_i = 8'hb0; m1_cti_i = '0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 8'hc0;
    push(1'b0, 8'hc0); push(1'b1, 8'hb0);
    tick();

    // Back-to-back alternation with both masters always re-requesting.
    for (int t = 0; t < 6; t++) begin
      grant_check($sformatf("alt%0d", t));
      s_ack_i = 0;
      if (t % 2 == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
      else            begin m1_cyc_i = 0; m1_stb_i = 0; end
      tick();
      if (t < 4) begin
        if (t % 2 == 0) begin
          nadr = 8'hc0 + 8'(t + 2);
          m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = nadr;
          push(1'b0, nadr);
        end else begin
          nadr = 8'hb0 + 8'(t + 2);
          m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = nadr;
          push(1'b1, nadr);
        end
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_idle_cyc", 32'(s_cyc_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter addr_width, default 8, meaning the word-address width passed to the boot ROM slave.
REQ-002 The block SHALL have parameter timeout, default 255, meaning the stalled-strobe cycles after which an error is returned (range 2..65535).
REQ-003 wb_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 wb_rst  in  1  synchronous, active-high reset.
REQ-005 m0_adr_i, m1_adr_i  in  addr_width each  word address from master 0 (instruction) and master 1 (data).
REQ-006 m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i  in  1 each  Wishbone cycle and strobe per master.
REQ-007 m0_cti_i, m1_cti_i  in  3 each; m0_bte_i, m1_bte_i  in  2 each  B3 burst tags per master.
REQ-008 m0_dat_o, m1_dat_o  out  32 each  read data, both driven from s_dat_i.
REQ-009 m0_ack_o, m1_ack_o, m0_err_o, m1_err_o  out  1 each  per-master acknowledge and error.
REQ-010 s_adr_o  out  addr_width; s_cyc_o, s_stb_o  out  1; s_cti_o  out  3; s_bte_o  out  2  slave request.
REQ-011 s_dat_i  in  32; s_ack_i  in  1  slave response.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OWN0, OWN1, held in a register.
REQ-013 IDLE: neither cyc -> IDLE; only mN_cyc_i -> OWNN; both -> the master not served last (last-served flag, reset value 1, so master 0 wins first).
REQ-014 OWNN: stay while mN_cyc_i=1, including across bursts and cti=3'b111 end-of-burst cycles; ownership is never preempted.
REQ-015 OWNN with mN_cyc_i=0: go to the other master's OWN state if its cyc=1, else IDLE; no idle cycle inserted.
REQ-016 Grant latency: a request in IDLE reaches the slave exactly 1 cycle after cyc is sampled high.
REQ-017 The last-served flag SHALL update to N on every entry into OWNN.
REQ-018 In IDLE: s_cyc_o=0, s_stb_o=0, s_adr_o=0, s_cti_o=0, s_bte_o=0.
REQ-019 In OWNN: s_adr_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o SHALL equal master N inputs combinationally from state (no added latency).
REQ-020 mN_ack_o SHALL equal s_ack_i AND state==OWNN; the non-owner's ack is always 0.
REQ-021 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-022 Watchdog: 16-bit counter cleared in IDLE, on any state change, on s_ack_i=1, or when s_stb_o=0; otherwise increments.
REQ-023 When the counter equals timeout-1 with s_stb_o=1 and s_ack_i=0, mN_err_o of the owner SHALL pulse high for exactly 1 cycle and the counter SHALL clear.
REQ-024 During the err cycle s_stb_o SHALL be forced to 0; ownership is retained until the owner drops cyc.
REQ-025 s_ack_i and err in the same cycle SHALL NOT occur (ack clears counter first); ack wins.
REQ-026 s_ack_i arriving in IDLE SHALL be ignored (no master acked).

Reset
REQ-027 While wb_rst=1 at a clock edge: state=IDLE, last-served=1, counter=0.
REQ-028 All s_* outputs and all mN_ack_o, mN_err_o SHALL be 0 from the first edge with wb_rst=1; mN_dat_o follows s_dat_i.
REQ-029 Reset asserted mid-burst SHALL abandon the transfer; the next grant after release follows REQ-013 with master 0 preferred.

Verification
REQ-030 After reset, m0 and m1 raise cyc/stb same cycle, adr 0x10/0x20 -> s_adr_o=0x10 one cycle later, m0_ack_o only; m0 drops cyc -> next cycle s_adr_o=0x20, m1 granted.
REQ-031 m1 holds a 4-beat incrementing burst (cti 010,010,010,111) while m0 requests -> all 4 acks go to m1, m0_ack_o stays 0, m0 granted the cycle after m1_cyc_i falls.
REQ-032 Both masters re-request continuously for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1 with no IDLE between.
REQ-033 timeout=4, slave never acks, m0 strobes -> m0_err_o high for 1 cycle on the 4th stalled cycle, s_stb_o=0 that cycle, m1_err_o stays 0.
REQ-034 wb_rst pulsed during m1 burst beat 2 -> all outputs 0 next edge; after release with both requesting, m0 granted first.
REQ-035 s_ack_i forced high in IDLE -> m0_ack_o=m1_ack_o=0.
